// File: rtl/rs_deint_pkg.sv
// Purpose: shared defaults, sync constants and geometry helpers for the Forney convolutional deinterleaver.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: DEF_I/DEF_M/DEF_W/DEF_N defaults, SYNC_BYTE/SYNC_BYTE_INV, branch_depth/branch_base/
//           ram_words/latency constant functions and a width helper.
package rs_deint_pkg;

    localparam int DEF_I = 12;
    localparam int DEF_M = 17;
    localparam int DEF_W = 8;
    localparam int DEF_N = 204;

    // Transport-stream sync byte and its inverted form (first packet of an 8-packet group).
    localparam logic [7:0] SYNC_BYTE     = 8'h47;
    localparam logic [7:0] SYNC_BYTE_INV = 8'hB8;

    // Branch j holds (I-1-j)*M bytes; the last branch is a straight wire.
    function automatic int branch_depth(input int i, input int m, input int j);
        return (i - 1 - j) * m;
    endfunction

    // Branches are packed back to back in one RAM, branch 0 first.
    function automatic int branch_base(input int i, input int m, input int j);
        int s;
        s = 0;
        for (int k = 0; k < j; k++) begin
            s += branch_depth(i, m, k);
        end
        return s;
    endfunction

    function automatic int ram_words(input int i, input int m);
        return (m * i * (i - 1)) / 2;
    endfunction

    // End-to-end interleaver+deinterleaver delay in bytes.
    function automatic int latency(input int i, input int m);
        return i * (i - 1) * m;
    endfunction

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int width_of(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/rs_deint_ram.sv
// Purpose: single-address read-before-write RAM holding all deinterleaver branch delay lines.
// Latency: 1 clk read; rdat_o returns the word stored before the write of the same cycle.
// Backpressure: none; an access happens on every cycle en_i is high.
// Ports: clk; en_i access strobe; addr_i shared read/write address; wdat_i write data; rdat_o read data.
module rs_deint_ram #(
    parameter int DEPTH = 1122,
    parameter int W     = 8,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdat_i,
    output logic [W-1:0]  rdat_o
);

    // Contents are deliberately not reset: the fill counter masks stale data.
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdat_q         <= mem_q[addr_i];
            mem_q[addr_i]  <= wdat_i;
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/rs_conv_deinterleaver.sv
// Purpose: Forney convolutional deinterleaver (I branches, M-byte delay unit) restoring RS codewords.
// Latency: CEO and Out_byte follow each CE by exactly 1 clk; Valid_out after I*(I-1)*M fill bytes.
// Backpressure: none; every CE produces one CEO, back-to-back strobes are accepted.
// Ports: clk, reset_n (async active-low); CE/input_byte/sync_in input strobe, byte and frame start;
//        Out_byte/CEO/Valid_out output byte, strobe and codeword-aligned flag.
// Option: define RS_DEINT_SYNC_CHECK_EN to add the sync_err output (bad sync byte or misaligned sync).
module rs_conv_deinterleaver
    import rs_deint_pkg::*;
#(
    parameter int I = DEF_I,
    parameter int M = DEF_M,
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         CE,
    input  logic [W-1:0] input_byte,
    input  logic         sync_in,
    output logic [W-1:0] Out_byte,
    output logic         CEO,
`ifdef RS_DEINT_SYNC_CHECK_EN
    output logic         sync_err,
`endif
    output logic         Valid_out
);

    localparam int RAM_WORDS = ram_words(I, M);
    localparam int AW        = width_of(RAM_WORDS);
    localparam int PW        = width_of(branch_depth(I, M, 0));
    localparam int BW        = width_of(I);
    localparam int LAT       = latency(I, M);
    localparam int FW        = width_of(LAT + 1);

    localparam logic [BW-1:0] LAST_BRANCH = BW'(I - 1);
    localparam logic [FW-1:0] LAT_F       = FW'(LAT);

    if ((I < 2) || (I > 16) || ((N % I) != 0)) begin : g_bad_param
        $error("rs_conv_deinterleaver: I must be in 2..16 and divide N");
    end

    // Per-branch base address and pointer wrap value, fixed at elaboration.
    logic [AW-1:0] base_tbl [I];
    logic [PW-1:0] wrap_tbl [I];

    for (genvar j = 0; j < I; j++) begin : g_tbl
        assign base_tbl[j] = AW'(branch_base(I, M, j));
        if (branch_depth(I, M, j) > 0) begin : g_mem
            assign wrap_tbl[j] = PW'(branch_depth(I, M, j) - 1);
        end else begin : g_pass
            assign wrap_tbl[j] = '0;
        end
    end

    logic [BW-1:0] b_q, b_d;
    logic [PW-1:0] ptr_q [I];
    logic [PW-1:0] ptr_d [I];
    logic [FW-1:0] fill_q, fill_d;
    logic          ceo_q, ceo_d;
    logic          valid_q, valid_d;
    logic          src_ram_q, src_ram_d;
    logic [W-1:0]  bypass_q, bypass_d;

    logic [BW-1:0] b_eff;
    logic          resync;
    logic          has_mem;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_rdat;

    always_comb begin
        // A sync byte always lands in branch 0; it is a resync only if we were elsewhere.
        b_eff    = sync_in ? '0 : b_q;
        resync   = sync_in && (b_q != '0);
        has_mem  = (b_eff != LAST_BRANCH);
        ram_en   = CE && has_mem;
        ram_addr = base_tbl[b_eff] + AW'(ptr_q[b_eff]);

        b_d       = b_q;
        ptr_d     = ptr_q;
        fill_d    = fill_q;
        valid_d   = valid_q;
        src_ram_d = src_ram_q;
        bypass_d  = bypass_q;
        ceo_d     = CE;

        if (CE) begin
            b_d = (b_eff == LAST_BRANCH) ? '0 : b_eff + 1'b1;
            if (has_mem) begin
                ptr_d[b_eff] = (ptr_q[b_eff] == wrap_tbl[b_eff]) ? '0 : ptr_q[b_eff] + 1'b1;
            end
            // The resync byte itself starts the new fill, so it counts as byte one;
            // this keeps the first valid output on codeword byte 0.
            if (resync) begin
                fill_d = FW'(1);
            end else if (fill_q != LAT_F) begin
                fill_d = fill_q + 1'b1;
            end
            valid_d   = !resync && (fill_q == LAT_F);
            src_ram_d = has_mem;
            if (!has_mem) begin
                bypass_d = input_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b_q <= '0;
            for (int j = 0; j < I; j++) begin
                ptr_q[j] <= '0;
            end
            fill_q    <= '0;
            ceo_q     <= 1'b0;
            valid_q   <= 1'b0;
            src_ram_q <= 1'b0;
            bypass_q  <= '0;
        end else begin
            b_q       <= b_d;
            ptr_q     <= ptr_d;
            fill_q    <= fill_d;
            ceo_q     <= ceo_d;
            valid_q   <= valid_d;
            src_ram_q <= src_ram_d;
            bypass_q  <= bypass_d;
        end
    end

    rs_deint_ram #(
        .DEPTH (RAM_WORDS),
        .W     (W),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .addr_i (ram_addr),
        .wdat_i (input_byte),
        .rdat_o (ram_rdat)
    );

    // RAM read data is not reset, so after reset the output selects the zeroed bypass register.
    assign Out_byte  = src_ram_q ? ram_rdat : bypass_q;
    assign CEO       = ceo_q;
    assign Valid_out = valid_q;

`ifdef RS_DEINT_SYNC_CHECK_EN
    logic sync_err_q, sync_err_d;

    always_comb begin
        sync_err_d = 1'b0;
        if (CE && sync_in) begin
            sync_err_d = ((input_byte != W'(SYNC_BYTE)) && (input_byte != W'(SYNC_BYTE_INV)))
                         || (b_q != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= sync_err_d;
        end
    end

    assign sync_err = sync_err_q;
`endif

endmodule

// File: doc/rs_conv_deinterleaver.md
Name: rs_conv_deinterleaver

Overview:
- Forney convolutional deinterleaver for the DVB RS(204,188) receive chain. Default I=12 branches, M=17.
- Sits directly upstream of RS_dec: takes interleaved bytes from the demapper/Viterbi side and restores contiguous 204-byte codewords.
- Output uses the decoder's strobe convention: one-clock CE per byte, with Valid_out marking codeword-aligned data.

Parameters:
- I, 12, number of branches; range 2..16.
- M, 17, delay unit in bytes; branch j holds (I-1-j)*M bytes.
- W, 8, byte width.
- N, 204, codeword length in bytes; I must divide N.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- CE  in  1  one-clock input strobe, one per byte; minimum spacing is 1 clk (back-to-back allowed).
- input_byte  in  W  input byte, qualified by CE.
- sync_in  in  1  qualified by CE; marks the first byte of an interleaved frame (the transport sync byte).
- Out_byte  out  W  deinterleaved byte.
- CEO  out  1  one-clock strobe per output byte.
- Valid_out  out  1  high while Out_byte carries filled, frame-aligned data.

Behaviour:
- Reset (async, reset_n=0): Out_byte=0, CEO=0, Valid_out=0, branch counter=0, all branch pointers=0, fill counter=0. RAM contents are not cleared.
- Branch select:
  - On CE, the byte enters branch b.
  - Next branch is (b+1) mod I.
  - CE with sync_in forces b=0 for that byte.
- Branch j, depth D_j=(I-1-j)*M:
  - D_j>0: read slot base_j+ptr_j (the oldest byte), write input_byte into the same slot (read-before-write), then ptr_j = (ptr_j+1) mod D_j. Wrap is at exactly D_j-1 -> 0.
  - D_{I-1}=0: the byte passes through with no RAM access.
- Base addresses: base_j = sum_{k<j} D_k. Total RAM = M*I*(I-1)/2 words (1122 for defaults).
- Latency:
  - CEO asserts exactly 1 clk after each CE; Out_byte is updated on the same edge and holds until the next CEO.
  - CE is never dropped or merged; input and output byte counts are equal.
- Fill counter:
  - Counts CE up to LAT=I*(I-1)*M (2244 = 11 frames for defaults), then saturates.
  - Valid_out rises on the CEO of the first output byte after LAT input bytes. That byte is the first byte of a codeword.
- Resync:
  - sync_in arriving with b==0 is a no-op.
  - sync_in arriving with b!=0 forces b=0, clears the fill counter and drops Valid_out on the next edge. Pointers are kept.
- sync_in without CE is ignored.
- CE during reset is ignored.
- Reset mid-operation restarts fill; the first LAT bytes out carry stale RAM data with Valid_out=0.

Optional Feature:
- Macro: RS_DEINT_SYNC_CHECK_EN.
- Defined:
  - Adds output sync_err (1 bit, reset 0).
  - On CE with sync_in, sync_err pulses for one clk (aligned with CEO) if input_byte is neither 8'h47 nor 8'hB8.
  - Also pulses if sync_in arrives with b!=0 (misalignment).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rs_deint_pkg:
  - Defaults I/M/W/N.
  - Constant functions branch_depth(j), branch_base(j), ram_words(), latency().
  - Constants SYNC_BYTE=8'h47 and SYNC_BYTE_INV=8'hB8.
- Sub-module rs_deint_ram: ram_words() x W synchronous RAM with one write port and one read port. Read and write use the same address in the same cycle and return old data (read-before-write).
- Top-level contents: branch/pointer counters, fill counter and output registers.

Test Plan:
- Strobe timing: reset, then CE every 8 clks (1 high, 7 low) with bytes 0x00.., sync_in on byte 0 -> exactly one CEO per CE, 1 clk later; Valid_out=0 for the first 2244 CEOs.
- Round trip:
  - Stimulus: a reference Forney interleaver (I=12, M=17) feeds 20 codewords of counting bytes (codeword n byte k = (n+k) mod 256).
  - After fill, Valid_out=1; the first valid Out_byte is codeword 0 byte 0, and all 204*k bytes match in order.
- Back-to-back CE: same stream with CE high every clk -> identical output sequence; CEO high every clk after the first.
- Resync: inject sync_in at b=5 mid-stream -> b=0 on that byte, Valid_out drops next clk, and re-rises only after 2244 further bytes, on a codeword boundary.
- Reset mid-operation: pull reset_n low for 3 clks after 1000 bytes -> all outputs 0 immediately (async); after release the full fill latency is required again.
- With RS_DEINT_SYNC_CHECK_EN: sync_in with byte 0x12 -> sync_err=1 for one clk; with 0x47 or 0xB8 -> sync_err stays 0.
